rgb2gray_stream: RTL and testbench

- Stage directly downstream of the demosaic block's 24-bit RGB sync FIFO.
- Reads RGB pixels from that FIFO and converts each to 8-bit luma: Y = (77R + 150G + 29B + 128) >> 8.
- Presents luma on a valid/ready stream to the Sobel front end, tagged with start-of-frame and end-of-line flags.
- Credit-based read control plus an internal output buffer guarantee no pixel loss under any ready pattern.

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/rgb2gray_obuf.sv | 53 +++++
 rtl/rgb2gray_stream.sv | 119 +++++++++++
 tb/tb_rgb2gray_stream.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and bus payload types for the Sobel front-end pixel path.
package sobel_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned SUM_W   = 17;

  localparam int unsigned LUMA_CR    = 77;
  localparam int unsigned LUMA_CG    = 150;
  localparam int unsigned LUMA_CB    = 29;
  localparam int unsigned LUMA_ROUND = 128;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] y;
  } gray_beat_t;

endpackage

// File: rtl/rgb2gray_obuf.sv
// Circular output buffer: push at tail, head always visible on dout, pop on handshake.
module rgb2gray_obuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is reset so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

  // Credit accounting upstream must make these impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && count == CW'(DEPTH)));
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == '0));

endmodule

// File: rtl/rgb2gray_stream.sv
// RGB-to-luma stage: credit-paced FIFO reads, 2-stage arithmetic, buffered valid/ready output.
module rgb2gray_stream
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned OBUF_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_not_empty,
  output logic             fifo_ren,
  input  logic [RGB_W-1:0] fifo_din,
  input  logic             gray_i_ready,
  output logic             gray_o_valid,
  output logic [PIX_W-1:0] gray_dout,
  output logic             gray_sof,
  output logic             gray_eol
);

  localparam int unsigned CRD_W  = $clog2(OBUF_DEPTH) + 1;
  localparam int unsigned BEAT_W = $bits(gray_beat_t);

  logic [CRD_W-1:0]   credit;
  logic               rd_en;
  logic               ren_d;
  logic               prod_v;
  logic [PROD_W-1:0]  prod_r;
  logic [PROD_W-1:0]  prod_g;
  logic [PROD_W-1:0]  prod_b;
  logic [SUM_W-1:0]   sum_c;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               take_c;
  gray_beat_t         wr_beat_c;
  gray_beat_t         rd_beat;
  logic [CRD_W-1:0]   ocount;

  // Reads are held off for one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_en <= 1'b0;
    else        rd_en <= 1'b1;
  end

  assign fifo_ren = rd_en && fifo_not_empty && (credit < CRD_W'(OBUF_DEPTH));
  assign take_c   = gray_o_valid && gray_i_ready;

  // Credits cover every pixel between the FIFO read and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= '0;
    end else begin
      case ({fifo_ren, take_c})
        2'b10:   credit <= credit + CRD_W'(1);
        2'b01:   credit <= credit - CRD_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ren_d  <= 1'b0;
      prod_v <= 1'b0;
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
    end else begin
      ren_d  <= fifo_ren;
      prod_v <= ren_d;
      if (ren_d) begin
        prod_r <= PROD_W'(LUMA_CR * fifo_din[23:16]);
        prod_g <= PROD_W'(LUMA_CG * fifo_din[15:8]);
        prod_b <= PROD_W'(LUMA_CB * fifo_din[7:0]);
      end
    end
  end

  // Peak sum is 65408, so bits [15:8] never need saturation.
  always_comb begin
    sum_c         = SUM_W'(prod_r) + SUM_W'(prod_g) + SUM_W'(prod_b) + SUM_W'(LUMA_ROUND);
    wr_beat_c.sof = (x == '0) && (y == '0);
    wr_beat_c.eol = (x == COORD_W'(IMG_W - 1));
    wr_beat_c.y   = PIX_W'(sum_c >> 8);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (prod_v) begin
      if (x == COORD_W'(IMG_W - 1)) begin
        x <= '0;
        y <= (y == COORD_W'(IMG_H - 1)) ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

  rgb2gray_obuf #(
    .DEPTH (OBUF_DEPTH),
    .W     (BEAT_W)
  ) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (prod_v),
    .din   (wr_beat_c),
    .pop   (take_c),
    .dout  (rd_beat),
    .count (ocount)
  );

  assign gray_o_valid = (ocount != '0);
  assign gray_dout    = rd_beat.y;
  assign gray_sof     = rd_beat.sof;
  assign gray_eol     = rd_beat.eol;

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Scoreboard bench for rgb2gray_stream on a 4x2 frame with directed RGB vectors.
module tb_rgb2gray_stream;

  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 2;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  y;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_not_empty = 1'b0;
  logic        fifo_ren;
  logic [23:0] fifo_din = '0;
  logic        gray_i_ready = 1'b0;
  logic        gray_o_valid;
  logic [7:0]  gray_dout;
  logic        gray_sof;
  logic        gray_eol;

  rgb2gray_stream #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .OBUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_not_empty (fifo_not_empty),
    .fifo_ren       (fifo_ren),
    .fifo_din       (fifo_din),
    .gray_i_ready   (gray_i_ready),
    .gray_o_valid   (gray_o_valid),
    .gray_dout      (gray_dout),
    .gray_sof       (gray_sof),
    .gray_eol       (gray_eol)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs [10];
  vec_t src [$];
  logic [9:0] exp_q [$];
  int   mx = 0, my = 0;
  int   mode = 0;          // 0: ready high, 1: ready low, 2: random
  bit   toggle = 0;
  bit   chk_toggle = 0;
  int   cyc = 0;
  int   ren_count = 0, sof_count = 0, eol_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Source model: serves the FIFO and predicts each pixel at read time.
  initial begin
    bit   ren_seen;
    bit   phase = 0;
    vec_t v;
    forever begin
      @(posedge clk);
      cyc++;
      ren_seen = fifo_ren && rst_n;
      #1;
      if (ren_seen && src.size() > 0) begin
        v = src.pop_front();
        fifo_din = v.rgb;
        exp_q.push_back({(mx == 0 && my == 0), (mx == int'(IMG_W) - 1), v.y});
        if (mx == int'(IMG_W) - 1) begin
          mx = 0;
          my = (my == int'(IMG_H) - 1) ? 0 : my + 1;
        end else begin
          mx++;
        end
      end
      phase = ~phase;
      fifo_not_empty = rst_n && (src.size() > 0) && (!toggle || phase);
      gray_i_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops expected pixels on each handshake and checks stall stability.
  initial begin
    bit         stalled = 0;
    logic [9:0] prev = '0;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
      end else begin
        if (fifo_ren) ren_count++;
        if (chk_toggle) chk("read_on_empty", {31'd0, fifo_ren && !fifo_not_empty}, 32'd0);
        if (stalled) chk("hold", {21'd0, gray_o_valid, gray_sof, gray_eol, gray_dout}, {22'd1, prev});
        if (gray_o_valid && gray_i_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", {22'd0, gray_sof, gray_eol, gray_dout}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", {22'd0, gray_sof, gray_eol, gray_dout}, {22'd0, e});
          end
          if (gray_sof) sof_count++;
          if (gray_eol) eol_count++;
        end
        stalled = gray_o_valid && !gray_i_ready;
        prev = {gray_sof, gray_eol, gray_dout};
      end
    end
  end

  task automatic push_vec(input int idx);
    src.push_back(vecs[idx]);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((src.size() != 0 || exp_q.size() != 0 || gray_o_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, (src.size() != 0 || exp_q.size() != 0 || gray_o_valid)}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src.delete();
    exp_q.delete();
    mx = 0;
    my = 0;
    #1;
    chk("rst_ren",   {31'd0, fifo_ren}, 32'd0);
    chk("rst_valid", {31'd0, gray_o_valid}, 32'd0);
    chk("rst_dout",  {24'd0, gray_dout}, 32'd0);
    chk("rst_sof",   {31'd0, gray_sof}, 32'd0);
    chk("rst_eol",   {31'd0, gray_eol}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c0, r0, s0, e0, k;
    vecs[0] = '{24'hFFFFFF, 8'd255};
    vecs[1] = '{24'hFF0000, 8'd77};
    vecs[2] = '{24'h00FF00, 8'd149};
    vecs[3] = '{24'h0000FF, 8'd29};
    vecs[4] = '{24'h000000, 8'd0};
    vecs[5] = '{24'h808080, 8'd128};
    vecs[6] = '{24'h102030, 8'd29};
    vecs[7] = '{24'hC86432, 8'd124};
    vecs[8] = '{24'h0A141E, 8'd18};
    vecs[9] = '{24'hFF8000, 8'd152};

    do_reset();

    // Single white pixel: latency and sof.
    mode = 0;
    push_vec(0);
    k = 0;
    while (!fifo_ren && k < 20) begin @(negedge clk); k++; end
    c0 = cyc;
    k = 0;
    while (!gray_o_valid && k < 20) begin @(negedge clk); k++; end
    chk("latency", 32'(cyc - c0), 32'd3);
    drain("drain_single", 50);

    // Primaries back-to-back at one pixel per clock.
    for (int i = 1; i <= 4; i++) push_vec(i);
    k = 0;
    while (!gray_o_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("throughput", {31'd0, gray_o_valid}, 32'd1);
    end
    drain("drain_primaries", 50);

    // Backpressure: only DEPTH reads may be in flight.
    mode = 1;
    repeat (3) @(negedge clk);
    r0 = ren_count;
    for (int i = 0; i < 8; i++) push_vec(i + 2);
    repeat (20) @(negedge clk);
    chk("credit_reads", 32'(ren_count - r0), 32'(DEPTH));
    chk("ren_blocked", {31'd0, fifo_ren}, 32'd0);
    chk("valid_held", {31'd0, gray_o_valid}, 32'd1);
    mode = 0;
    drain("drain_backpressure", 200);

    // Full frame plus one pixel with random ready.
    do_reset();
    mode = 2;
    s0 = sof_count;
    e0 = eol_count;
    for (int i = 0; i < 9; i++) push_vec(i);
    drain("drain_frame", 400);
    chk("sof_count", 32'(sof_count - s0), 32'd2);
    chk("eol_count", 32'(eol_count - e0), 32'd2);

    // FIFO occupancy toggling every cycle.
    toggle = 1;
    chk_toggle = 1;
    for (int i = 0; i < 6; i++) push_vec(9 - i);
    drain("drain_toggle", 400);
    chk_toggle = 0;
    toggle = 0;

    // Reset with pixels buffered; next output must restart the frame.
    mode = 1;
    for (int i = 0; i < 3; i++) push_vec(i + 5);
    repeat (10) @(negedge clk);
    chk("pre_reset_valid", {31'd0, gray_o_valid}, 32'd1);
    do_reset();
    mode = 0;
    s0 = sof_count;
    push_vec(7);
    drain("drain_after_reset", 50);
    chk("sof_after_reset", 32'(sof_count - s0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
